// File: rtl/rb_rr_scheduler_if.sv
// rtl/rb_rr_scheduler_if.sv - ring-buffer side and output side signal bundle of rb_rr_scheduler
interface rb_rr_scheduler_if #(
  parameter int NB_QUEUES = 4,
  parameter int DWIDTH    = 64,
  parameter int AWIDTH    = 9,
  parameter int QWIDTH    = $clog2(NB_QUEUES)
);
  logic [NB_QUEUES*AWIDTH-1:0] q_occup;
  logic [NB_QUEUES*DWIDTH-1:0] q_rd_data;
  logic [NB_QUEUES-1:0]        q_rd_en;
  logic [NB_QUEUES-1:0]        q_enable;
  logic [DWIDTH-1:0]           out_data;
  logic [QWIDTH-1:0]           out_qid;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    input  q_occup, q_rd_data, q_enable, out_ready,
    output q_rd_en, out_data, out_qid, out_valid
  );

  modport slave (
    output q_occup, q_rd_data, q_enable, out_ready,
    input  q_rd_en, out_data, out_qid, out_valid
  );
endinterface

// File: rtl/rb_rr_scheduler.sv
// rtl/rb_rr_scheduler.sv - burst round-robin drain of prefetch ring buffers into a 2-entry skid
module rb_rr_scheduler #(
  parameter int NB_QUEUES = 4,
  parameter int DWIDTH    = 64,
  parameter int AWIDTH    = 9,
  parameter int BURST     = 4
) (
  input  logic               clk,
  input  logic               rst,
  rb_rr_scheduler_if.master  bus
);
  localparam int QWIDTH = $clog2(NB_QUEUES);
  localparam logic [7:0] BURST_MAX = 8'(BURST);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [QWIDTH-1:0]    cur_q, cur_q_nxt, search_q, grant_q;
  logic [7:0]           burst_cnt, burst_nxt;
  logic                 rst_r;
  logic [AWIDTH-1:0]    occ_r [NB_QUEUES];
  logic [NB_QUEUES-1:0] eligible;
  logic [NB_QUEUES-1:0] rd_en;
  logic                 any_elig, found, keep, pop, xfer;

  logic [DWIDTH-1:0]    skid_data [2];
  logic [QWIDTH-1:0]    skid_qid  [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           skid_cnt;

  // occ_r stays cleared through the ring buffers' delayed reset cycle
  always_ff @(posedge clk) begin
    rst_r <= rst;
    for (int i = 0; i < NB_QUEUES; i++) begin
      if (rst || rst_r) occ_r[i] <= '0;
      else              occ_r[i] <= bus.q_occup[i*AWIDTH +: AWIDTH];
    end
  end

  always_comb begin
    for (int i = 0; i < NB_QUEUES; i++) eligible[i] = (occ_r[i] != '0) && bus.q_enable[i];
    any_elig = |eligible;
  end

  // Rotating search: cur_q+1 first, cur_q itself as the last candidate
  always_comb begin
    found    = 1'b0;
    search_q = cur_q;
    for (int k = 1; k <= NB_QUEUES; k++) begin
      if (!found && eligible[(int'(cur_q) + k) % NB_QUEUES]) begin
        found    = 1'b1;
        search_q = QWIDTH'((int'(cur_q) + k) % NB_QUEUES);
      end
    end
  end

  assign keep    = (state == SERVE) && eligible[cur_q] && (burst_cnt < BURST_MAX);
  assign grant_q = keep ? cur_q : search_q;
  assign pop     = !rst && !rst_r && (skid_cnt <= 2'd1) && any_elig;
  assign xfer    = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_q     <= QWIDTH'(NB_QUEUES - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cur_q     <= cur_q_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_q_nxt = cur_q;
    burst_nxt = burst_cnt;
    if (!any_elig) begin
      state_nxt = IDLE;
      burst_nxt = '0;
    end else if (pop) begin
      state_nxt = SERVE;
      if (keep) begin
        burst_nxt = burst_cnt + 8'd1;
      end else begin
        cur_q_nxt = search_q;
        burst_nxt = 8'd1;
      end
    end
  end

  always_comb begin
    rd_en = '0;
    if (pop) rd_en[grant_q] = 1'b1;
  end

  assign bus.q_rd_en = rd_en;

  // Two-entry skid FIFO: a pop lands here in the same cycle, outputs are its head
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      skid_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        skid_data[i] <= '0;
        skid_qid[i]  <= '0;
      end
    end else begin
      if (pop) begin
        skid_data[wr_ptr] <= bus.q_rd_data[int'(grant_q)*DWIDTH +: DWIDTH];
        skid_qid[wr_ptr]  <= grant_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (xfer) rd_ptr <= ~rd_ptr;
      case ({pop, xfer})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  assign bus.out_valid = (skid_cnt != 2'd0);
  assign bus.out_data  = skid_data[rd_ptr];
  assign bus.out_qid   = skid_qid[rd_ptr];
endmodule

// File: tb/tb_rb_rr_scheduler.sv
// tb/tb_rb_rr_scheduler.sv - directed self-checking bench for rb_rr_scheduler
module tb_rb_rr_scheduler;
  localparam int NBQ = 4;
  localparam int DW  = 64;
  localparam int AW  = 9;
  localparam int BST = 4;
  localparam int QW  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rb_rr_scheduler_if #(.NB_QUEUES(NBQ), .DWIDTH(DW), .AWIDTH(AW)) bus ();

  rb_rr_scheduler #(.NB_QUEUES(NBQ), .DWIDTH(DW), .AWIDTH(AW), .BURST(BST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ring buffers: occupancy is reported net of the same-cycle pop
  logic [DW-1:0]   qmem [NBQ][64];
  int unsigned     head [NBQ];
  int unsigned     tail [NBQ];
  logic [NBQ-1:0]  nonempty;

  always_comb begin
    for (int i = 0; i < NBQ; i++) begin
      nonempty[i] = (tail[i] != head[i]);
      bus.q_occup[i*AW +: AW] = AW'(tail[i] - head[i] - ((bus.q_rd_en[i] && nonempty[i]) ? 1 : 0));
      bus.q_rd_data[i*DW +: DW] = qmem[i][head[i] % 64];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NBQ; i++)
      if (bus.q_rd_en[i] && nonempty[i]) head[i] <= head[i] + 1;
  end

  int cyc;
  int n_pops;
  int viol;
  logic [DW-1:0] got_d [$];
  logic [QW-1:0] got_q [$];
  int            got_c [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready && !rst) begin
      got_d.push_back(bus.out_data);
      got_q.push_back(bus.out_qid);
      got_c.push_back(cyc);
    end
    if (bus.q_rd_en != '0) n_pops <= n_pops + 1;
    if ($countones(bus.q_rd_en) > 1 || (bus.q_rd_en & ~nonempty) != '0) viol <= viol + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] ent(input int q, input int unsigned s);
    return {8'(q), 56'(s)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int q);
    qmem[q][tail[q] % 64] = ent(q, tail[q]);
    tail[q] = tail[q] + 1;
  endtask

  task automatic clear_got();
    got_d.delete();
    got_q.delete();
    got_c.delete();
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (got_d.size() >= n) break;
      tick();
    end
  endtask

  // Returns in the cycle right after reset falls (delayed-reset cycle)
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NBQ; i++) tail[i] = head[i];
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int unsigned b0;
    rst = 1'b1;
    bus.q_enable = 4'hF;
    bus.out_ready = 1'b1;
    tick();
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); end
    n_vec++; if (bus.out_data !== '0) begin n_err++; $display("FAIL rst_out_data got %0h want 0", bus.out_data); end
    n_vec++; if (bus.out_qid !== '0) begin n_err++; $display("FAIL rst_out_qid got %0d want 0", bus.out_qid); end
    n_vec++; if (bus.q_rd_en !== 4'b0000) begin n_err++; $display("FAIL rst_rd_en got %b want 0000", bus.q_rd_en); end
    tick();
    tick();
    rst = 1'b0;
    clear_got();
    b0 = tail[0];
    push(0);
    push(0);
    @(negedge clk);
    n_vec++; if (bus.q_rd_en !== 4'b0000) begin n_err++; $display("FAIL rst_r_cycle_rd_en got %b want 0000", bus.q_rd_en); end
    tick();
    @(negedge clk);
    n_vec++; if (bus.q_rd_en !== 4'b0000) begin n_err++; $display("FAIL occ_clear_cycle_rd_en got %b want 0000", bus.q_rd_en); end
    tick();
    @(negedge clk);
    n_vec++; if (bus.q_rd_en !== 4'b0001) begin n_err++; $display("FAIL first_grant_rd_en got %b want 0001", bus.q_rd_en); end
    wait_out(2, 20);
    n_vec++; if (got_d.size() !== 2) begin n_err++; $display("FAIL reset_drain_count got %0d want 2", got_d.size()); end
    for (int k = 0; k < 2 && k < got_d.size(); k++) begin
      n_vec++; if (got_d[k] !== ent(0, b0 + k)) begin n_err++; $display("FAIL reset_drain_data[%0d] got %0h want %0h", k, got_d[k], ent(0, b0 + k)); end
    end
    repeat (4) tick();
  endtask

  task automatic test_rr_order();
    int unsigned base [NBQ];
    int q, s;
    do_reset();
    tick();
    clear_got();
    for (int i = 0; i < NBQ; i++) begin
      base[i] = tail[i];
      for (int j = 0; j < 8; j++) push(i);
    end
    wait_out(32, 100);
    n_vec++; if (got_d.size() !== 32) begin n_err++; $display("FAIL rr_count got %0d want 32", got_d.size()); end
    for (int k = 0; k < 32 && k < got_d.size(); k++) begin
      q = (k % 16) / 4;
      s = (k / 16) * 4 + (k % 4);
      n_vec++; if (got_q[k] !== QW'(q) || got_d[k] !== ent(q, base[q] + s)) begin
        n_err++; $display("FAIL rr_order[%0d] got q%0d %0h want q%0d %0h", k, got_q[k], got_d[k], q, ent(q, base[q] + s));
      end
    end
    if (got_c.size() == 32) begin
      n_vec++; if (got_c[31] - got_c[0] !== 31) begin n_err++; $display("FAIL rr_throughput span got %0d want 31", got_c[31] - got_c[0]); end
    end
    n_vec++; if (viol !== 0) begin n_err++; $display("FAIL rr_rd_en_legal got %0d violations want 0", viol); end
    repeat (4) tick();
  endtask

  task automatic test_single_queue();
    int unsigned b2;
    clear_got();
    b2 = tail[2];
    for (int j = 0; j < 5; j++) push(2);
    wait_out(5, 40);
    n_vec++; if (got_d.size() !== 5) begin n_err++; $display("FAIL single_count got %0d want 5", got_d.size()); end
    for (int k = 0; k < 5 && k < got_d.size(); k++) begin
      n_vec++; if (got_q[k] !== 2'd2 || got_d[k] !== ent(2, b2 + k)) begin
        n_err++; $display("FAIL single_order[%0d] got q%0d %0h want q2 %0h", k, got_q[k], got_d[k], ent(2, b2 + k));
      end
    end
    if (got_c.size() == 5) begin
      n_vec++; if (got_c[4] - got_c[0] !== 4) begin n_err++; $display("FAIL single_regrant span got %0d want 4", got_c[4] - got_c[0]); end
    end
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    int unsigned b1;
    int p0;
    clear_got();
    bus.out_ready = 1'b0;
    b1 = tail[1];
    p0 = n_pops;
    for (int j = 0; j < 6; j++) push(1);
    repeat (10) tick();
    n_vec++; if (n_pops - p0 !== 2) begin n_err++; $display("FAIL stall_pops got %0d want 2", n_pops - p0); end
    @(negedge clk);
    n_vec++; if (bus.q_rd_en !== 4'b0000) begin n_err++; $display("FAIL stall_rd_en got %b want 0000", bus.q_rd_en); end
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid got %0b want 1", bus.out_valid); end
    tick();
    bus.out_ready = 1'b1;
    wait_out(6, 40);
    n_vec++; if (got_d.size() !== 6) begin n_err++; $display("FAIL release_count got %0d want 6", got_d.size()); end
    for (int k = 0; k < 6 && k < got_d.size(); k++) begin
      n_vec++; if (got_q[k] !== 2'd1 || got_d[k] !== ent(1, b1 + k)) begin
        n_err++; $display("FAIL release_order[%0d] got q%0d %0h want q1 %0h", k, got_q[k], got_d[k], ent(1, b1 + k));
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_trickle();
    int unsigned b1, b3;
    int pcyc [4];
    int i1, i3;
    clear_got();
    b1 = tail[1];
    b3 = tail[3];
    for (int j = 0; j < 20; j++) push(3);
    for (int j = 0; j < 4; j++) begin
      push(1);
      pcyc[j] = cyc;
      repeat (3) tick();
    end
    wait_out(24, 100);
    n_vec++; if (got_d.size() !== 24) begin n_err++; $display("FAIL trickle_count got %0d want 24", got_d.size()); end
    i1 = 0;
    i3 = 0;
    for (int k = 0; k < got_d.size(); k++) begin
      if (got_q[k] == 2'd1 && i1 < 4) begin
        n_vec++; if (got_d[k] !== ent(1, b1 + i1)) begin n_err++; $display("FAIL trickle_q1[%0d] got %0h want %0h", i1, got_d[k], ent(1, b1 + i1)); end
        n_vec++; if (got_c[k] - pcyc[i1] > NBQ * BST + 2) begin n_err++; $display("FAIL trickle_q1_latency[%0d] got %0d want <= %0d", i1, got_c[k] - pcyc[i1], NBQ * BST + 2); end
        i1++;
      end else begin
        n_vec++; if (got_q[k] !== 2'd3 || got_d[k] !== ent(3, b3 + i3)) begin
          n_err++; $display("FAIL trickle_q3[%0d] got q%0d %0h want q3 %0h", i3, got_q[k], got_d[k], ent(3, b3 + i3));
        end
        i3++;
      end
    end
    n_vec++; if (viol !== 0) begin n_err++; $display("FAIL trickle_rd_en_legal got %0d violations want 0", viol); end
    repeat (4) tick();
  endtask

  task automatic test_enable_drop();
    int eq [16] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int es [16] = '{0, 1, 0, 1, 2, 3, 2, 3, 4, 5, 4, 5, 6, 7, 6, 7};
    int unsigned base [2];
    do_reset();
    tick();
    clear_got();
    base[0] = tail[0];
    base[1] = tail[1];
    for (int j = 0; j < 8; j++) begin
      push(0);
      push(1);
    end
    repeat (3) tick();
    bus.q_enable = 4'b1110;
    repeat (4) tick();
    bus.q_enable = 4'b1111;
    wait_out(16, 60);
    n_vec++; if (got_d.size() !== 16) begin n_err++; $display("FAIL endrop_count got %0d want 16", got_d.size()); end
    for (int k = 0; k < 16 && k < got_d.size(); k++) begin
      n_vec++; if (got_q[k] !== QW'(eq[k]) || got_d[k] !== ent(eq[k], base[eq[k]] + es[k])) begin
        n_err++; $display("FAIL endrop_order[%0d] got q%0d %0h want q%0d %0h", k, got_q[k], got_d[k], eq[k], ent(eq[k], base[eq[k]] + es[k]));
      end
    end
    if (got_c.size() == 16) begin
      n_vec++; if (got_c[15] - got_c[0] !== 15) begin n_err++; $display("FAIL endrop_span got %0d want 15", got_c[15] - got_c[0]); end
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_midstream();
    int unsigned b0, b2;
    for (int i = 0; i < NBQ; i++)
      for (int j = 0; j < 8; j++) push(i);
    repeat (6) tick();
    rst = 1'b1;
    for (int i = 0; i < NBQ; i++) tail[i] = head[i];
    @(negedge clk);
    n_vec++; if (bus.q_rd_en !== 4'b0000) begin n_err++; $display("FAIL midrst_pulse_rd_en got %b want 0000", bus.q_rd_en); end
    tick();
    rst = 1'b0;
    clear_got();
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %0b want 0", bus.out_valid); end
    n_vec++; if (bus.q_rd_en !== 4'b0000) begin n_err++; $display("FAIL midrst_rd_en_1 got %b want 0000", bus.q_rd_en); end
    tick();
    b0 = tail[0];
    b2 = tail[2];
    push(2);
    push(2);
    push(0);
    push(0);
    @(negedge clk);
    n_vec++; if (bus.q_rd_en !== 4'b0000) begin n_err++; $display("FAIL midrst_rd_en_2 got %b want 0000", bus.q_rd_en); end
    tick();
    @(negedge clk);
    n_vec++; if (bus.q_rd_en !== 4'b0001) begin n_err++; $display("FAIL midrst_first_grant got %b want 0001", bus.q_rd_en); end
    wait_out(4, 30);
    n_vec++; if (got_d.size() !== 4) begin n_err++; $display("FAIL midrst_count got %0d want 4", got_d.size()); end
    for (int k = 0; k < 4 && k < got_d.size(); k++) begin
      n_vec++; if (got_d[k] !== ((k < 2) ? ent(0, b0 + k) : ent(2, b2 + k - 2))) begin
        n_err++; $display("FAIL midrst_order[%0d] got %0h want %0h", k, got_d[k], (k < 2) ? ent(0, b0 + k) : ent(2, b2 + k - 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_single_queue();
    test_backpressure();
    test_trickle();
    test_enable_drop();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d want bench completion", cyc);
    $fatal(1);
  end
endmodule
